// File: rtl/branch_resolve_pipe_pkg.sv
// Shared RV32I branch types: funct3 encodings and the resolved-branch record
// carried down the resolve pipeline (fields sized for PCs up to 64 bits, tags up to 16).
package rv32i_types;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  localparam int BR_PC_W  = 64;
  localparam int BR_TAG_W = 16;

  typedef struct packed {
    logic                taken;
    logic [BR_PC_W-1:0]  next_pc;
    logic                mispredict;
    logic                illegal;
    logic [BR_TAG_W-1:0] tag;
  } br_res_t;

endpackage

// File: rtl/branch_resolve_pipe_br_cmp.sv
// Combinational branch comparator: decodes funct3 and evaluates the condition
// at full WIDTH, flagging the two non-branch encodings as illegal.
module br_cmp
  import rv32i_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       cmpop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             br_en,
  output logic             illegal
);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    eq;
  logic                    lt_s;
  logic                    lt_u;

  assign a_s  = a;
  assign b_s  = b;
  assign eq   = (a == b);
  assign lt_s = (a_s < b_s);
  assign lt_u = (a < b);

  always_comb begin
    br_en   = 1'b0;
    illegal = 1'b0;
    case (cmpop)
      F3_BEQ:  br_en = eq;
      F3_BNE:  br_en = ~eq;
      F3_BLT:  br_en = lt_s;
      F3_BGE:  br_en = ~lt_s;
      F3_BLTU: br_en = lt_u;
      F3_BGEU: br_en = ~lt_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_pipe.sv
// Branch resolution pipeline: compare and target/fallthrough adds in the first
// stage, then STAGES-1 elastic delay stages with valid/ready backpressure.
module branch_resolve_pipe
  import rv32i_types::*;
#(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       cmpop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic             pred_taken,
  input  logic [WIDTH-1:0] pred_target,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [WIDTH-1:0] out_next_pc,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      br_cnt,
  output logic [31:0]      mispred_cnt
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic             br_en;
  logic             op_illegal;
  logic             taken;
  logic             mispredict;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] fallthru;
  logic [WIDTH-1:0] next_pc;
  br_res_t          res_in;

  br_cmp #(.WIDTH(WIDTH)) u_cmp (
    .cmpop   (cmpop),
    .a       (a),
    .b       (b),
    .br_en   (br_en),
    .illegal (op_illegal)
  );

  assign target     = pc + imm;
  assign fallthru   = pc + WIDTH'(4);
  assign taken      = br_en & ~op_illegal;
  assign next_pc    = taken ? target : fallthru;
  assign mispredict = (taken != pred_taken) |
                      (taken & pred_taken & (target != pred_target));

  always_comb begin
    res_in            = '0;
    res_in.taken      = taken;
    res_in.next_pc    = BR_PC_W'(next_pc);
    res_in.mispredict = mispredict;
    res_in.illegal    = op_illegal;
    res_in.tag        = BR_TAG_W'(tag);
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;

  // A stage moves when it is empty or its successor moves; the tail follows out_ready.
  always_comb begin
    adv             = '0;
    adv[STAGES-1]   = ~vld[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = ~vld[i] | adv[i+1];
    end
  end

  assign in_ready = adv[0] & ~flush & ~rst;

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    logic    vld_q;
    logic    vld_d;
    br_res_t res_q;
    br_res_t res_d;

    if (s == 0) begin : g_src
      // stage p0 boundary: freshly resolved branch enters here
      assign vld_d = in_valid & in_ready;
      assign res_d = res_in;
    end else begin : g_src
      // stage p1+ boundary: pure delay of the previous stage
      assign vld_d = g_stg[s-1].vld_q;
      assign res_d = g_stg[s-1].res_q;
    end

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        vld_q <= 1'b0;
      end else if (adv[s]) begin
        vld_q <= vld_d;
      end
    end

    always_ff @(posedge clk) begin
      if (adv[s] && vld_d) begin
        res_q <= res_d;
      end
    end

    assign vld[s] = vld_q;
  end

  br_res_t res_out;
  logic    unused_res;
  logic    out_hs;

  assign res_out        = g_stg[STAGES-1].res_q;
  assign unused_res     = ^res_out;
  assign out_valid      = vld[STAGES-1];
  assign out_taken      = res_out.taken;
  assign out_next_pc    = res_out.next_pc[WIDTH-1:0];
  assign out_mispredict = res_out.mispredict;
  assign out_illegal    = res_out.illegal;
  assign out_tag        = res_out.tag[TAG_W-1:0];

  // A result shown during flush is dropped, so it never counts.
  assign out_hs = out_valid & out_ready & ~flush & ~rst;

  logic [31:0] br_cnt_q;
  logic [31:0] mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else if (out_hs && !res_out.illegal) begin
      br_cnt_q <= sat_inc(br_cnt_q);
      if (res_out.mispredict) begin
        mispred_cnt_q <= sat_inc(mispred_cnt_q);
      end
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Directed bench for branch_resolve_pipe (WIDTH=32, TAG_W=4, STAGES=2).
module tb_branch_resolve_pipe;

  localparam int WIDTH  = 32;
  localparam int TAG_W  = 4;
  localparam int STAGES = 2;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_ILL  = 3'b010;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       cmpop = '0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH-1:0] pc = '0;
  logic [WIDTH-1:0] imm = '0;
  logic             pred_taken = 1'b0;
  logic [WIDTH-1:0] pred_target = '0;
  logic [TAG_W-1:0] tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_taken;
  logic [WIDTH-1:0] out_next_pc;
  logic             out_mispredict;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      br_cnt;
  logic [31:0]      mispred_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_br = '0;
  logic [31:0] exp_mp = '0;

  logic             r_ok;
  logic             r_taken;
  logic             r_mp;
  logic             r_ill;
  logic [WIDTH-1:0] r_npc;
  logic [TAG_W-1:0] r_tag;
  int               r_lat;

  branch_resolve_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .cmpop          (cmpop),
    .a              (a),
    .b              (b),
    .pc             (pc),
    .imm            (imm),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .tag            (tag),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_taken      (out_taken),
    .out_next_pc    (out_next_pc),
    .out_mispredict (out_mispredict),
    .out_illegal    (out_illegal),
    .out_tag        (out_tag),
    .br_cnt         (br_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive_req(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] vpc, input logic [31:0] vimm, input logic pt,
                           input logic [31:0] ptgt, input logic [3:0] t);
    cmpop = op; a = va; b = vb; pc = vpc; imm = vimm;
    pred_taken = pt; pred_target = ptgt; tag = t; in_valid = 1'b1;
  endtask

  // Sends one request from a negedge and captures its result; returns at a negedge.
  task automatic run_one(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] vpc, input logic [31:0] vimm, input logic pt,
                         input logic [31:0] ptgt, input logic [3:0] t);
    int w;
    r_ok = 1'b0;
    drive_req(op, va, vb, vpc, vimm, pt, ptgt, t);
    #1;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clk); #1; w++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    r_lat = 1;
    while (out_valid !== 1'b1 && r_lat < 20) begin
      @(negedge clk); r_lat++;
    end
    if (out_valid === 1'b1) begin
      r_ok = 1'b1; r_taken = out_taken; r_mp = out_mispredict;
      r_ill = out_illegal; r_npc = out_next_pc; r_tag = out_tag;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (br_cnt !== 32'h0) begin bad++; $display("FAIL reset_br_cnt: got %0h want 0", br_cnt); end
    total++; if (mispred_cnt !== 32'h0) begin bad++; $display("FAIL reset_mp_cnt: got %0h want 0", mispred_cnt); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_signed_split();
    run_one(OP_BLT, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 4'd1);
    exp_br++; exp_mp++;
    total++; if (r_ok !== 1'b1 || r_tag !== 4'd1) begin bad++; $display("FAIL blt_result: ok %b tag %0h want ok 1 tag 1", r_ok, r_tag); end
    total++; if (r_taken !== 1'b1) begin bad++; $display("FAIL blt_taken: got %b want 1", r_taken); end
    total++; if (r_npc !== 32'h120) begin bad++; $display("FAIL blt_next_pc: got %0h want 120", r_npc); end
    run_one(OP_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 4'd2);
    exp_br++;
    total++; if (r_ok !== 1'b1 || r_taken !== 1'b0) begin bad++; $display("FAIL bltu_taken: ok %b got %b want 0", r_ok, r_taken); end
    total++; if (r_npc !== 32'h104 || r_mp !== 1'b0) begin bad++; $display("FAIL bltu_npc_mp: got %0h/%b want 104/0", r_npc, r_mp); end
    total++; if (br_cnt !== exp_br || mispred_cnt !== exp_mp) begin bad++; $display("FAIL split_counters: got %0h/%0h want %0h/%0h", br_cnt, mispred_cnt, exp_br, exp_mp); end
  endtask

  task automatic test_mispredict_wrap();
    run_one(OP_BEQ, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'h8, 1'b0, 32'h0, 4'd3);
    exp_br++; exp_mp++;
    total++; if (r_ok !== 1'b1 || r_lat != STAGES) begin bad++; $display("FAIL wrap_latency: ok %b got %0d want %0d", r_ok, r_lat, STAGES); end
    total++; if (r_taken !== 1'b1 || r_npc !== 32'h4 || r_mp !== 1'b1) begin bad++; $display("FAIL wrap_result: got %b/%0h/%b want 1/4/1", r_taken, r_npc, r_mp); end
    run_one(OP_BNE, 32'd1, 32'd2, 32'h1000, 32'hFFFF_FFF0, 1'b1, 32'h1000, 4'd4);
    exp_br++; exp_mp++;
    total++; if (r_taken !== 1'b1 || r_npc !== 32'hFF0 || r_mp !== 1'b1) begin bad++; $display("FAIL bne_target_miss: got %b/%0h/%b want 1/ff0/1", r_taken, r_npc, r_mp); end
    run_one(OP_BGE, 32'd3, 32'd3, 32'h2000, 32'h40, 1'b1, 32'h2040, 4'd5);
    exp_br++;
    total++; if (r_taken !== 1'b1 || r_npc !== 32'h2040 || r_mp !== 1'b0) begin bad++; $display("FAIL bge_hit: got %b/%0h/%b want 1/2040/0", r_taken, r_npc, r_mp); end
    run_one(OP_BGEU, 32'd0, 32'hFFFF_FFFF, 32'h3000, 32'h10, 1'b0, 32'h0, 4'd6);
    exp_br++;
    total++; if (r_taken !== 1'b0 || r_npc !== 32'h3004 || r_mp !== 1'b0) begin bad++; $display("FAIL bgeu_not_taken: got %b/%0h/%b want 0/3004/0", r_taken, r_npc, r_mp); end
    total++; if (br_cnt !== exp_br || mispred_cnt !== exp_mp) begin bad++; $display("FAIL wrap_counters: got %0h/%0h want %0h/%0h", br_cnt, mispred_cnt, exp_br, exp_mp); end
  endtask

  task automatic test_illegal();
    run_one(OP_ILL, 32'd0, 32'd0, 32'h400, 32'h10, 1'b1, 32'h410, 4'd7);
    total++; if (r_ok !== 1'b1 || r_ill !== 1'b1) begin bad++; $display("FAIL illegal_flag: ok %b got %b want 1", r_ok, r_ill); end
    total++; if (r_taken !== 1'b0 || r_mp !== 1'b1 || r_npc !== 32'h404) begin bad++; $display("FAIL illegal_result: got %b/%b/%0h want 0/1/404", r_taken, r_mp, r_npc); end
    total++; if (br_cnt !== exp_br || mispred_cnt !== exp_mp) begin bad++; $display("FAIL illegal_counters: got %0h/%0h want %0h/%0h", br_cnt, mispred_cnt, exp_br, exp_mp); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got  = 0;
    logic [TAG_W-1:0] st_tag = '0;
    logic [WIDTH-1:0] st_npc = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      if (sent < 6) drive_req(OP_BEQ, sent, sent, sent * 16, 32'h8, 1'b1, sent * 16 + 8, sent[3:0]);
      else in_valid = 1'b0;
      #1;
      if (cyc == 2) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        st_tag = out_tag; st_npc = out_next_pc;
      end
      if (cyc == 3 || cyc == 4) begin
        total++;
        if (out_valid !== 1'b1 || out_tag !== st_tag || out_next_pc !== st_npc) begin
          bad++; $display("FAIL bp_stable: got %b/%0h/%0h want 1/%0h/%0h", out_valid, out_tag, out_next_pc, st_tag, st_npc);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        total++;
        if (out_tag !== got[3:0] || out_next_pc !== 32'(got * 16 + 8)) begin
          bad++; $display("FAIL bp_order: got tag %0h pc %0h want tag %0h pc %0h", out_tag, out_next_pc, got[3:0], got * 16 + 8);
        end
        got++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    exp_br = exp_br + 6;
    total++; if (got != 6) begin bad++; $display("FAIL bp_count: got %0d want 6", got); end
    total++; if (br_cnt !== exp_br || mispred_cnt !== exp_mp) begin bad++; $display("FAIL bp_counters: got %0h/%0h want %0h/%0h", br_cnt, mispred_cnt, exp_br, exp_mp); end
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    out_ready = 1'b1;
    drive_req(OP_BEQ, 32'd1, 32'd1, 32'h500, 32'h8, 1'b0, 32'h0, 4'd10);
    @(posedge clk); @(negedge clk);
    drive_req(OP_BEQ, 32'd1, 32'd1, 32'h600, 32'h8, 1'b0, 32'h0, 4'd11);
    @(posedge clk); @(negedge clk);
    drive_req(OP_BEQ, 32'd1, 32'd1, 32'h700, 32'h8, 1'b0, 32'h0, 4'd12);
    flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b1 || out_tag !== 4'd10) begin bad++; $display("FAIL flush_inflight: got %b/%0h want 1/a", out_valid, out_tag); end
    @(posedge clk); @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    repeat (5) begin
      #1; if (out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_dropped: got %b want 0", seen); end
    total++; if (br_cnt !== exp_br || mispred_cnt !== exp_mp) begin bad++; $display("FAIL flush_counters: got %0h/%0h want %0h/%0h", br_cnt, mispred_cnt, exp_br, exp_mp); end
  endtask

  task automatic test_saturation();
    force dut.br_cnt_q = 32'hFFFF_FFFD;
    force dut.mispred_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.br_cnt_q;
    release dut.mispred_cnt_q;
    #1;
    total++; if (br_cnt !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sat_preload: got %0h want fffffffd", br_cnt); end
    run_one(OP_BEQ, 32'd2, 32'd2, 32'h800, 32'h8, 1'b0, 32'h0, 4'd1);
    total++; if (br_cnt !== 32'hFFFF_FFFE || mispred_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_step1: got %0h/%0h want fffffffe/ffffffff", br_cnt, mispred_cnt); end
    run_one(OP_BEQ, 32'd2, 32'd2, 32'h800, 32'h8, 1'b0, 32'h0, 4'd2);
    run_one(OP_BEQ, 32'd2, 32'd2, 32'h800, 32'h8, 1'b0, 32'h0, 4'd3);
    total++; if (br_cnt !== 32'hFFFF_FFFF || mispred_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold: got %0h/%0h want ffffffff/ffffffff", br_cnt, mispred_cnt); end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    drive_req(OP_BNE, 32'd1, 32'd2, 32'h900, 32'h8, 1'b0, 32'h0, 4'd5);
    @(posedge clk); @(negedge clk);
    drive_req(OP_BNE, 32'd1, 32'd2, 32'hA00, 32'h8, 1'b0, 32'h0, 4'd6);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b/%b want 0/0", out_valid, in_ready); end
    total++; if (br_cnt !== 32'h0 || mispred_cnt !== 32'h0) begin bad++; $display("FAIL rst_mid_counters: got %0h/%0h want 0/0", br_cnt, mispred_cnt); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    repeat (4) begin
      @(negedge clk); #1; if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_abandon: got %b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_signed_split();
    test_mispredict_wrap();
    test_illegal();
    test_backpressure();
    test_flush();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/branch_resolve_pipe.md
BRANCH_RESOLVE_PIPE -- requirements
Module: branch_resolve_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, PC and immediate width.
REQ-002 SHALL have parameter TAG_W, default 4: instruction tag width.
REQ-003 SHALL have parameter STAGES, default 2, legal 1..4: register stages from input to output.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL provide ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  kill all in-flight entries.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid and in_ready are both high.
- cmpop  in  3  branch funct3.
- a, b  in  WIDTH  rs1 and rs2 values.
- pc, imm  in  WIDTH  branch PC and sign-extended offset.
- pred_taken  in  1  front-end prediction.
- pred_target  in  WIDTH  predicted target.
- tag  in  TAG_W  instruction tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_taken  out  1  resolved direction.
- out_next_pc  out  WIDTH  correct next PC.
- out_mispredict  out  1  redirect required.
- out_illegal  out  1  cmpop not a branch encoding.
- out_tag  out  TAG_W  tag passed through.
- br_cnt, mispred_cnt  out  32  statistics counters.

Function
REQ-006 SHALL decode cmpop as beq=000, bne=001, blt=100, bge=101, bltu=110, bgeu=111.
REQ-007 SHALL compare signed for blt/bge and unsigned for bltu/bgeu, at full WIDTH.
REQ-008 SHALL treat cmpop 010/011 as illegal: out_taken=0, out_illegal=1, and out_mispredict=pred_taken.
REQ-009 SHALL compute target as pc+imm modulo 2^WIDTH.
REQ-010 SHALL compute fallthrough as pc+4 modulo 2^WIDTH.
REQ-011 SHALL drive out_next_pc = taken ? target : fallthrough.
REQ-012 SHALL assert out_mispredict = (taken != pred_taken) | (taken & pred_taken & target != pred_target).
REQ-013 SHALL evaluate the compare and both adds in the first stage.
REQ-014 SHALL pass later stages as pure delay registers, each with its own valid bit.
REQ-015 SHALL present a result with out_valid exactly STAGES cycles after acceptance when out_ready stays high.
REQ-016 SHALL advance stage i when it is empty or stage i+1 advances; the last stage advances on out_ready.
REQ-017 SHALL assert in_ready = (first stage advances) & ~flush, so full throughput is 1 per cycle.
REQ-018 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-019 SHALL clear every stage valid on the edge where flush=1, with no transfer accepted that cycle.
REQ-020 SHALL drop a result presented on a flush cycle even if out_ready=1: no handshake and no counter update.
REQ-021 SHALL increment br_cnt on each output handshake, saturating at 0xFFFFFFFF.
REQ-022 SHALL increment mispred_cnt on each handshake with out_mispredict=1, saturating at 0xFFFFFFFF.
REQ-023 SHALL not count illegal results in either counter.
REQ-024 SHALL keep out_* data don't-care while out_valid=0; the bench checks data only when out_valid=1.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear all stage valids, out_valid, br_cnt and mispred_cnt to 0.
REQ-026 SHALL drive in_ready=0 during reset.
REQ-027 SHALL abandon in-flight entries on reset mid-operation.
REQ-028 SHALL give rst priority over flush and handshakes.
REQ-029 SHALL hold in_ready high from the first cycle after rst deasserts.

Structure
REQ-030 SHALL take the branch funct3 enum and a branch-result struct (taken, next_pc, mispredict, illegal, tag) from rv32i_types.
REQ-031 SHALL place the compare in sub-module br_cmp (cmpop, a, b -> br_en, illegal), combinational and WIDTH-parametrised.
REQ-032 SHALL generate the stage registers with a loop over STAGES.

Verification
REQ-033 SHALL cover signed/unsigned split: WIDTH=32, blt and bltu with a=0xFFFFFFFF, b=1 -> blt taken=1, bltu taken=0.
REQ-034 SHALL cover mispredict and wrap: beq a=b=5, pc=0xFFFFFFFC, imm=8, pred_taken=0 -> taken=1, next_pc=0x00000004, mispredict=1, result after STAGES cycles.
REQ-035 SHALL cover backpressure: STAGES=2, 6 back-to-back requests, out_ready low for 3 cycles -> in_ready drops once the pipe is full, outputs stay stable, all 6 tags emerge in order with no loss.
REQ-036 SHALL cover flush: flush pulsed with 2 entries in flight and in_valid=1 -> in_ready=0 that cycle, those entries never appear, counters unchanged.
REQ-037 SHALL cover illegal op: cmpop=010, pred_taken=1 -> out_illegal=1, taken=0, mispredict=1, br_cnt unchanged.
REQ-038 SHALL cover saturation and reset: br_cnt forced near max, 3 handshakes -> stays 0xFFFFFFFF; rst mid-stream -> out_valid=0 and counters=0 next cycle.
